// File: rtl/multi_counter_pkg.sv
// ============================================================================
// multi_counter_pkg
// Shared helpers for the multi-channel event counter.
//   sel_width() : width of a channel-select field for a given channel count
//   norm_div()  : maps a zero divisor to one; every other value passes through
//   ALL_ONES    : wide all-ones constant, sliced to the counter width for the
//                 saturation / overflow compare (supports WIDTH up to MAX_W)
// Optional feature macro used by the files importing this package:
//   MULTI_COUNTER_OVF_EN
// ============================================================================
package multi_counter_pkg;

   localparam int unsigned MAX_W = 256;
   localparam logic [MAX_W-1:0] ALL_ONES = '1;

   // A single channel still needs a one-bit select so the port exists.
   function automatic int sel_width(input int ch_num);
      return (ch_num > 1) ? $clog2(ch_num) : 1;
   endfunction

   // Divisor values are carried at 64 bits here and cast back by the caller.
   function automatic logic [63:0] norm_div(input logic [63:0] d);
      return (d == 64'd0) ? 64'd1 : d;
   endfunction

endpackage

// File: rtl/multi_counter_channel.sv
// ============================================================================
// counter_channel
// One channel of the event counter: divisor register, prescaler and main
// counter, plus the optional sticky overflow bit.
// Ports:
//   clk     in   clock, posedge
//   rst     in   synchronous active-high reset
//   hit     in   an event addressed to this channel this cycle
//   clr     in   clear prescaler, counter (and overflow); wins over cfg/hit
//   cfg_we  in   load a new divisor; restarts the prescaler, drops the hit
//   cfg_div in   new divisor (0 is stored as 1)
//   sat     in   0 = wrap at all-ones, 1 = hold at all-ones
//   count   out  main counter value
//   div     out  current divisor
//   ovf     out  sticky overflow (only with MULTI_COUNTER_OVF_EN defined)
// ============================================================================
module counter_channel
   import multi_counter_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int PRESC_W = 8,
   parameter int DEF_DIV = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hit,
   input  logic               clr,
   input  logic               cfg_we,
   input  logic [PRESC_W-1:0] cfg_div,
   input  logic               sat,
`ifdef MULTI_COUNTER_OVF_EN
   output logic               ovf,
`endif
   output logic [WIDTH-1:0]   count,
   output logic [PRESC_W-1:0] div
);

   localparam logic [WIDTH-1:0]   CNT_MAX = ALL_ONES[WIDTH-1:0];
   localparam logic [PRESC_W-1:0] DIV_RST = PRESC_W'(norm_div(64'(DEF_DIV)));

   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [PRESC_W-1:0] pre_q, pre_d;
   logic [PRESC_W-1:0] div_q, div_d;
   logic               ovf_q, ovf_d;

   always_comb begin
      cnt_d = cnt_q;
      pre_d = pre_q;
      div_d = div_q;
      ovf_d = ovf_q;
      if (clr) begin
         cnt_d = '0;
         pre_d = '0;
         ovf_d = 1'b0;
      end else if (cfg_we) begin
         div_d = PRESC_W'(norm_div(64'(cfg_div)));
         pre_d = '0;
      end else if (hit) begin
         // pre never exceeds div-1: every divisor change restarts it at 0.
         if (pre_q == div_q - PRESC_W'(1)) begin
            pre_d = '0;
            if (cnt_q == CNT_MAX) begin
               ovf_d = 1'b1;
               cnt_d = sat ? CNT_MAX : '0;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            pre_d = pre_q + PRESC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         pre_q <= '0;
         div_q <= DIV_RST;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pre_q <= pre_d;
         div_q <= div_d;
         ovf_q <= ovf_d;
      end
   end

   assign count = cnt_q;
   assign div   = div_q;

`ifdef MULTI_COUNTER_OVF_EN
   assign ovf = ovf_q;
`else
   // Overflow state is only observable when the feature is built in.
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: rtl/multi_counter.sv
// ============================================================================
// multi_counter
// Parametrised multi-channel event counter. One event per cycle is steered
// to channel Sel; each channel has its own prescaler and main counter.
// Optional sticky overflow outputs are built when MULTI_COUNTER_OVF_EN is
// defined.
// Ports:
//   Clk     in   clock, posedge
//   Reset   in   synchronous active-high reset
//   En      in   event strobe
//   Sel     in   channel receiving the event (out-of-range: dropped)
//   Sat     in   0 = wrap, 1 = saturate
//   Clr     in   per-channel clear
//   CfgWe   in   divisor write strobe
//   CfgSel  in   channel whose divisor is written (out-of-range: ignored)
//   CfgDiv  in   new divisor (0 stored as 1)
//   Count   out  channel i at [i*WIDTH +: WIDTH]
//   Div     out  channel i at [i*PRESC_W +: PRESC_W]
//   Ovf     out  per-channel sticky overflow (MULTI_COUNTER_OVF_EN only)
// ============================================================================
module multi_counter
   import multi_counter_pkg::*;
#(
   parameter int  CH_NUM  = 2,
   parameter int  WIDTH   = 64,
   parameter int  PRESC_W = 8,
   parameter int  DEF_DIV = 1,
   localparam int SEL_W   = sel_width(CH_NUM)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      En,
   input  logic [SEL_W-1:0]          Sel,
   input  logic                      Sat,
   input  logic [CH_NUM-1:0]         Clr,
   input  logic                      CfgWe,
   input  logic [SEL_W-1:0]          CfgSel,
   input  logic [PRESC_W-1:0]        CfgDiv,
`ifdef MULTI_COUNTER_OVF_EN
   output logic [CH_NUM-1:0]         Ovf,
`endif
   output logic [CH_NUM*WIDTH-1:0]   Count,
   output logic [CH_NUM*PRESC_W-1:0] Div
);

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      // Select values >= CH_NUM match no channel, so those events and
      // writes fall away without extra logic.
      logic hit, cfg_hit;
      assign hit     = En    && (Sel    == SEL_W'(i));
      assign cfg_hit = CfgWe && (CfgSel == SEL_W'(i));

      counter_channel #(
         .WIDTH   (WIDTH),
         .PRESC_W (PRESC_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk     (Clk),
         .rst     (Reset),
         .hit     (hit),
         .clr     (Clr[i]),
         .cfg_we  (cfg_hit),
         .cfg_div (CfgDiv),
         .sat     (Sat),
`ifdef MULTI_COUNTER_OVF_EN
         .ovf     (Ovf[i]),
`endif
         .count   (Count[i*WIDTH +: WIDTH]),
         .div     (Div[i*PRESC_W +: PRESC_W])
      );
   end

endmodule

// File: tb/tb_multi_counter.sv
module tb_multi_counter;
   localparam int CH  = 3;
   localparam int W   = 8;
   localparam int PW  = 8;
   localparam int SW  = 2;
   localparam int MAXV = 255;

   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic             En = 1'b0;
   logic [SW-1:0]    Sel = '0;
   logic             Sat = 1'b0;
   logic [CH-1:0]    Clr = '0;
   logic             CfgWe = 1'b0;
   logic [SW-1:0]    CfgSel = '0;
   logic [PW-1:0]    CfgDiv = '0;
   logic [CH*W-1:0]  Count;
   logic [CH*PW-1:0] Div;
`ifdef MULTI_COUNTER_OVF_EN
   logic [CH-1:0]    Ovf;
`endif

   multi_counter #(.CH_NUM(CH), .WIDTH(W), .PRESC_W(PW), .DEF_DIV(1)) dut (
      .Clk(Clk), .Reset(Reset), .En(En), .Sel(Sel), .Sat(Sat), .Clr(Clr),
      .CfgWe(CfgWe), .CfgSel(CfgSel), .CfgDiv(CfgDiv),
`ifdef MULTI_COUNTER_OVF_EN
      .Ovf(Ovf),
`endif
      .Count(Count), .Div(Div)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   bit model_on = 0;

   // Behavioural model: plain integers per channel.
   int m_cnt [CH];
   int m_pre [CH];
   int m_div [CH];
   int m_ovf [CH];

   always @(posedge Clk) begin
      for (int i = 0; i < CH; i++) begin
         if (Reset) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_div[i] = 1; m_ovf[i] = 0;
         end else if (Clr[i]) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
         end else if (CfgWe && int'(CfgSel) == i) begin
            m_div[i] = (CfgDiv == 0) ? 1 : int'(CfgDiv);
            m_pre[i] = 0;
         end else if (En && int'(Sel) == i) begin
            m_pre[i] = m_pre[i] + 1;
            if (m_pre[i] >= m_div[i]) begin
               m_pre[i] = 0;
               if (m_cnt[i] == MAXV) begin
                  m_ovf[i] = 1;
                  m_cnt[i] = Sat ? MAXV : 0;
               end else begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end
         end
      end
   end

   // Compare process: every cycle once the model has been reset.
   always @(negedge Clk) begin
      if (model_on) begin
         for (int i = 0; i < CH; i++) begin
            checks++;
            if (int'(Count[i*W +: W]) != m_cnt[i]) begin
               errors++;
               $display("FAIL model_count[%0d] t=%0t got %0d want %0d", i, $time, Count[i*W +: W], m_cnt[i]);
            end
            checks++;
            if (int'(Div[i*PW +: PW]) != m_div[i]) begin
               errors++;
               $display("FAIL model_div[%0d] t=%0t got %0d want %0d", i, $time, Div[i*PW +: PW], m_div[i]);
            end
`ifdef MULTI_COUNTER_OVF_EN
            checks++;
            if (int'(Ovf[i]) != m_ovf[i]) begin
               errors++;
               $display("FAIL model_ovf[%0d] t=%0t got %0d want %0d", i, $time, Ovf[i], m_ovf[i]);
            end
`endif
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic lit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic int cnt(input int i);
      return int'(Count[i*W +: W]);
   endfunction

   function automatic int dv(input int i);
      return int'(Div[i*PW +: PW]);
   endfunction

   task automatic events(input int s, input int n);
      for (int k = 0; k < n; k++) begin
         En = 1'b1; Sel = SW'(s);
         tick();
      end
      En = 1'b0;
   endtask

   task automatic cfg(input int s, input int d);
      CfgWe = 1'b1; CfgSel = SW'(s); CfgDiv = PW'(d);
      tick();
      CfgWe = 1'b0;
   endtask

   task automatic clr(input int ch);
      Clr = '0; Clr[ch] = 1'b1;
      tick();
      Clr = '0;
   endtask

   int snap0, snap1, snap2;

   initial begin
      // Reset
      Reset = 1'b1;
      tick();
      model_on = 1;
      tick();
      Reset = 1'b0;
      lit("reset_count0", cnt(0), 0);
      lit("reset_count1", cnt(1), 0);
      lit("reset_div0", dv(0), 1);
      lit("reset_div1", dv(1), 1);

      // 10 events to channel 0 with divisor 1
      events(0, 10);
      lit("ten_events_count0", cnt(0), 10);
      lit("ten_events_count1", cnt(1), 0);

      // Divisor 4 on channel 1
      cfg(1, 4);
      lit("cfg_div1", dv(1), 4);
      events(1, 9);
      lit("div4_nine_count1", cnt(1), 2);
      events(1, 1);
      lit("div4_ten_count1", cnt(1), 2);
      events(1, 1);
      lit("div4_eleven_count1", cnt(1), 2);
      events(1, 1);
      lit("div4_twelve_count1", cnt(1), 3);

      // Clear with a same-channel event
      cfg(1, 1);
      events(1, 2);
      lit("pre_clear_count1", cnt(1), 5);
      Clr = 3'b010; En = 1'b1; Sel = 2'd1;
      tick();
      Clr = '0; En = 1'b0;
      lit("clr_same_ch_count1", cnt(1), 0);

      // Clear on channel 1 while channel 0 counts
      events(1, 2);
      snap0 = cnt(0);
      Clr = 3'b010; En = 1'b1; Sel = 2'd0;
      tick();
      Clr = '0; En = 1'b0;
      lit("clr_other_count1", cnt(1), 0);
      lit("clr_other_count0", cnt(0), snap0 + 1);

      // Divisor write of 0 with a same-channel event
      snap0 = cnt(0);
      CfgWe = 1'b1; CfgSel = 2'd0; CfgDiv = 8'd0; En = 1'b1; Sel = 2'd0;
      tick();
      CfgWe = 1'b0; En = 1'b0;
      lit("cfg_zero_div0", dv(0), 1);
      lit("cfg_zero_count0_held", cnt(0), snap0);
      events(0, 1);
      lit("cfg_zero_next_event", cnt(0), snap0 + 1);

      // Config on channel 2 while channel 1 counts
      CfgWe = 1'b1; CfgSel = 2'd2; CfgDiv = 8'd3; En = 1'b1; Sel = 2'd1;
      tick();
      CfgWe = 1'b0; En = 1'b0;
      lit("cfg_other_div2", dv(2), 3);
      lit("cfg_other_count1", cnt(1), 1);

      // Wrap at all-ones
      clr(0);
      Sat = 1'b0;
      events(0, 255);
      lit("preload_255", cnt(0), 255);
      events(0, 1);
      lit("wrap_count0", cnt(0), 0);
`ifdef MULTI_COUNTER_OVF_EN
      lit("wrap_ovf0", int'(Ovf[0]), 1);
      clr(0);
      lit("clr_ovf0", int'(Ovf[0]), 0);
`else
      clr(0);
`endif

      // Saturate at all-ones
      events(0, 255);
      Sat = 1'b1;
      events(0, 2);
      lit("sat_count0", cnt(0), 255);
`ifdef MULTI_COUNTER_OVF_EN
      lit("sat_ovf0", int'(Ovf[0]), 1);
`endif
      Sat = 1'b0;
      events(0, 1);
      lit("sat_release_wrap", cnt(0), 0);

      // Out-of-range select and config are ignored
      events(0, 3);
      snap0 = cnt(0); snap1 = cnt(1); snap2 = cnt(2);
      CfgWe = 1'b1; CfgSel = 2'd3; CfgDiv = 8'd7;
      events(3, 5);
      CfgWe = 1'b0;
      lit("oob_count0", cnt(0), snap0);
      lit("oob_count1", cnt(1), snap1);
      lit("oob_count2", cnt(2), snap2);
      lit("oob_div2", dv(2), 3);

      // Reset mid-sequence discards prescaler progress and divisors
      cfg(1, 4);
      events(1, 2);
      Reset = 1'b1; En = 1'b1; Sel = 2'd0;
      tick();
      Reset = 1'b0; En = 1'b0;
      lit("midreset_count0", cnt(0), 0);
      lit("midreset_count1", cnt(1), 0);
      lit("midreset_div1", dv(1), 1);
      lit("midreset_div2", dv(2), 1);
      events(1, 1);
      lit("post_reset_event1", cnt(1), 1);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
